// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bus for serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C_out;

  modport master (
    output start, A, B, C_in,
    input  busy, done, Sum, C_out
  );

  modport slave (
    input  start, A, B, C_in,
    output busy, done, Sum, C_out
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, LSB first, one bit per clock
// Sum/C_out are only written on entry to DONE so they hold between completions.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [CW-1:0]    cnt_q;

  logic [1:0]       ha0, ha1;
  logic             s_bit, carry_d, last_bit;
  logic [WIDTH-1:0] res_d;

  // {carry, sum}
  function automatic logic [1:0] half_adder(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  always_comb begin
    ha0      = half_adder(a_q[0], b_q[0]);
    ha1      = half_adder(ha0[0], carry_q);
    s_bit    = ha1[0];
    carry_d  = ha0[1] | ha1[1];
    res_d    = WIDTH'({s_bit, res_q} >> 1);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.C_in;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            sum_q   <= res_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.Sum   = sum_q;
  assign bus.C_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) s8();
  serial_adder_if #(.WIDTH(1)) s1();

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(s8));
  serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(s1));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: result is plain A+B+C_in, done lands WIDTH edges after acceptance.
  bit       m8_act, m1_act;
  int       m8_n, m1_n;
  logic [8:0] m8_res, m8_out;
  logic [1:0] m1_res, m1_out;

  initial begin
    m8_act = 0; m1_act = 0; m8_n = 0; m1_n = 0;
    m8_res = '0; m8_out = '0; m1_res = '0; m1_out = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m8_act = 0; m8_out = '0;
      m1_act = 0; m1_out = '0;
    end else begin
      if (m8_act) begin
        m8_n++;
        if (m8_n == 8) m8_out = m8_res;
        if (m8_n == 9) m8_act = 0;
      end else if (s8.start) begin
        m8_act = 1; m8_n = 0;
        m8_res = 9'(s8.A) + 9'(s8.B) + 9'(s8.C_in);
      end
      if (m1_act) begin
        m1_n++;
        if (m1_n == 1) m1_out = m1_res;
        if (m1_n == 2) m1_act = 0;
      end else if (s1.start) begin
        m1_act = 1; m1_n = 0;
        m1_res = 2'(s1.A) + 2'(s1.B) + 2'(s1.C_in);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8_busy", 32'(s8.busy), 32'(m8_act && m8_n < 8));
      chk("m8_done", 32'(s8.done), 32'(m8_act && m8_n == 8));
      chk("m8_sum",  32'({s8.C_out, s8.Sum}), 32'(m8_out));
      chk("m1_busy", 32'(s1.busy), 32'(m1_act && m1_n < 1));
      chk("m1_done", 32'(s1.done), 32'(m1_act && m1_n == 1));
      chk("m1_sum",  32'({s1.C_out, s1.Sum}), 32'(m1_out));
    end
  end

  // Called at a negedge; leaves the bench at the first negedge after the accept edge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    s8.start = 1'b1; s8.A = a; s8.B = b; s8.C_in = c;
    @(negedge clk);
    s8.start = 1'b0; s8.A = 8'($urandom); s8.B = 8'($urandom); s8.C_in = 1'($urandom);
  endtask

  task automatic go1(input logic a, input logic b, input logic c);
    s1.start = 1'b1; s1.A = a; s1.B = b; s1.C_in = c;
    @(negedge clk);
    s1.start = 1'b0; s1.A = 1'($urandom); s1.B = 1'($urandom); s1.C_in = 1'($urandom);
  endtask

  // Returns the cycle number (1 = first cycle after accept) in which done is seen.
  task automatic wait_done(input int w, output int cyc);
    cyc = 1;
    while (((w == 1) ? s1.done : s8.done) !== 1'b1) begin
      if (cyc >= 50) begin
        chk("done_timeout", 32'(cyc), 32'(0));
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [1:0] fa_tt [8];
  int lat, ndone;

  initial begin
    fa_tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst_n = 1'b0;
    s8.start = 0; s8.A = 0; s8.B = 0; s8.C_in = 0;
    s1.start = 0; s1.A = 0; s1.B = 0; s1.C_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(s8.busy), 0);
    chk("rst_done", 32'(s8.done), 0);
    chk("rst_sum",  32'({s8.C_out, s8.Sum}), 0);
    chk("rst_sum1", 32'({s1.C_out, s1.Sum}), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    go8(8'h3C, 8'h45, 1'b0);
    chk("t1_busy_c1", 32'(s8.busy), 1);
    wait_done(8, lat);
    chk("t1_lat", 32'(lat), 9);
    chk("t1_sum", 32'({s8.C_out, s8.Sum}), 32'h081);
    @(negedge clk);

    go8(8'hFF, 8'h01, 1'b0);
    wait_done(8, lat);
    chk("t2a_sum", 32'({s8.C_out, s8.Sum}), 32'h100);
    @(negedge clk);
    go8(8'hFF, 8'hFF, 1'b1);
    wait_done(8, lat);
    chk("t2b_sum", 32'({s8.C_out, s8.Sum}), 32'h1FF);
    @(negedge clk);

    go8(8'h10, 8'h20, 1'b0);
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) begin s8.start = 1'b1; s8.A = 8'hAA; s8.B = 8'h55; end
      if (i == 3) s8.start = 1'b0;
      if (s8.done) ndone++;
      @(negedge clk);
    end
    chk("t3_ndone", 32'(ndone), 1);
    chk("t3_sum", 32'({s8.C_out, s8.Sum}), 32'h030);

    go8(8'h12, 8'h34, 1'b0);
    wait_done(8, lat);
    chk("t4_sum", 32'({s8.C_out, s8.Sum}), 32'h046);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s8.done || s8.Sum != 8'h46) ndone++;
    end
    chk("t4_hold", 32'(ndone), 0);
    go8(8'h01, 8'h01, 1'b0);
    ndone = 0;
    for (int i = 0; i < 50 && !s8.done; i++) begin
      if (s8.Sum != 8'h46) ndone++;
      @(negedge clk);
    end
    chk("t4_hold_busy", 32'(ndone), 0);
    chk("t4_new_sum", 32'({s8.C_out, s8.Sum}), 32'h002);
    @(negedge clk);

    go8(8'h7F, 8'h7F, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", 32'(s8.busy), 0);
    chk("t5_rst_done", 32'(s8.done), 0);
    chk("t5_rst_sum", 32'({s8.C_out, s8.Sum}), 0);
    rst_n = 1'b1;
    go8(8'h05, 8'h03, 1'b0);
    wait_done(8, lat);
    chk("t5_lat", 32'(lat), 9);
    chk("t5_sum", 32'({s8.C_out, s8.Sum}), 32'h008);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      go1(v[2], v[1], v[0]);
      wait_done(1, lat);
      chk($sformatf("w1_lat_%0d", i), 32'(lat), 2);
      chk($sformatf("w1_tt_%0d", i), 32'({s1.C_out, s1.Sum}), 32'(fa_tt[i]));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
